// File: rtl/ocp_prot_checker.sv
// OCP request/response protocol checker.
//
// Passively watches one OCP master/slave link and flags protocol violations.
//   Clk_i, MReset_i (async, active-high), Clear_i (sync clear of sticky/counters)
//   MCmd_i, MAddr_i, MByteEn_i, MData_i, SCmdAccept_i, SResp_i : observed OCP signals
//   Err_o         : per-cycle violation pulses (combinational)
//   ErrSticky_o   : OR of all Err_o since reset/clear
//   ErrCnt_o      : saturating count of cycles with any violation
//   Outstanding_o : requests still awaiting a response
//   ReqCnt_o      : accepted non-IDLE commands (wrapping)
//   RespCnt_o     : non-NULL responses (wrapping)
//
// Err_o bits: [0] MCmd X/Z, [1] hold violation, [2] illegal command, [3] misaligned
// address, [4] FAIL without WRC at head, [5] response with nothing outstanding,
// [6] outstanding overflow, [7] response timeout.
module ocp_prot_checker #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned WR_RESP   = 0,
    parameter int unsigned ALLOW_WRC = 0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                Clk_i,
    input  logic                MReset_i,
    input  logic                Clear_i,
    input  logic [2:0]          MCmd_i,
    input  logic [ADDR_W-1:0]   MAddr_i,
    input  logic [DATA_W/8-1:0] MByteEn_i,
    input  logic [DATA_W-1:0]   MData_i,
    input  logic                SCmdAccept_i,
    input  logic [1:0]          SResp_i,
    output logic [7:0]          Err_o,
    output logic [7:0]          ErrSticky_o,
    output logic [15:0]         ErrCnt_o,
    output logic [3:0]          Outstanding_o,
    output logic [31:0]         ReqCnt_o,
    output logic [31:0]         RespCnt_o
);

    localparam int unsigned BeW = DATA_W / 8;

    localparam logic [2:0] CmdIdle = 3'b000;
    localparam logic [2:0] CmdWr   = 3'b001;
    localparam logic [2:0] CmdRd   = 3'b010;
    localparam logic [2:0] CmdWrc  = 3'b110;

    localparam logic [1:0] RespNull = 2'b00;
    localparam logic [1:0] RespFail = 2'b10;

    // Low address bits that must be zero for a bus-aligned access (none for 8-bit data).
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(BeW - 1);
    localparam logic [3:0]        MaxOut    = 4'(MAX_OUT);
    localparam logic [9:0]        TmoLast   = 10'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BeW-1:0]      be_q;
    logic [DATA_W-1:0]   data_q;
    logic                capture;

    logic [3:0]          out_q, out_d;
    logic [MAX_OUT-1:0]  fifo_q, fifo_d;   // 1 = WRC, index 0 is the oldest request
    logic [9:0]          tmo_q, tmo_d;
    logic [7:0]          sticky_q, sticky_d;
    logic [15:0]         errcnt_q, errcnt_d;
    logic [31:0]         reqcnt_q, reqcnt_d;
    logic [31:0]         respcnt_q, respcnt_d;

    logic       cmd_active, accept, is_wrc, expects, push, resp, pop, do_push, tmo_fire;
    logic [7:0] err_raw;
    int         widx;

    assign cmd_active = (MCmd_i != CmdIdle);
    assign accept     = cmd_active && SCmdAccept_i;
    assign is_wrc     = (MCmd_i == CmdWrc);
    assign expects    = (MCmd_i == CmdRd) || is_wrc || ((MCmd_i == CmdWr) && (WR_RESP != 0));
    assign push       = accept && expects;
    assign resp       = (SResp_i != RespNull);
    assign pop        = resp && (out_q != 4'd0);
    // A request is dropped when it would overflow, or when it coincides with a
    // response that had nothing to match (the count is pinned at 0 then).
    assign do_push    = push && (pop || (!resp && (out_q != MaxOut)));
    assign tmo_fire   = (out_q != 4'd0) && !resp && (tmo_q == TmoLast);

    // Request FSM: WAIT holds a presented command until the slave accepts it.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_active && !SCmdAccept_i) begin
                    state_d = StWait;
                    capture = 1'b1;
                end
            end
            StWait: begin
                if (SCmdAccept_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_raw    = '0;
        err_raw[0] = $isunknown(MCmd_i);
        err_raw[1] = (state_q == StWait) &&
                     ((MCmd_i !== cmd_q) || (MAddr_i !== addr_q) ||
                      (MByteEn_i !== be_q) || (MData_i !== data_q));
        err_raw[2] = cmd_active &&
                     !((MCmd_i == CmdWr) || (MCmd_i == CmdRd) || (is_wrc && (ALLOW_WRC != 0)));
        err_raw[3] = cmd_active && ((MAddr_i & AlignMask) != '0);
        err_raw[4] = (SResp_i == RespFail) && !((out_q != 4'd0) && fifo_q[0]);
        err_raw[5] = resp && (out_q == 4'd0);
        err_raw[6] = push && !resp && (out_q == MaxOut);
        err_raw[7] = tmo_fire;
    end

    assign Err_o = MReset_i ? 8'h00 : err_raw;

    // Outstanding count and in-order WRC tracking FIFO.
    always_comb begin
        out_d  = out_q;
        fifo_d = fifo_q;
        widx   = int'(out_q);
        if (pop) begin
            fifo_d = fifo_q >> 1;
            widx   = int'(out_q) - 1;
        end
        if (do_push) begin
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                if (i == widx) fifo_d[i] = is_wrc;
            end
        end
        if (do_push && !pop) begin
            out_d = out_q + 4'd1;
        end else if (pop && !do_push) begin
            out_d = out_q - 4'd1;
        end
    end

    always_comb begin
        tmo_d = (out_q == 4'd0 || resp || tmo_fire) ? 10'd0 : tmo_q + 10'd1;
    end

    // Statistics; Clear_i has priority over any same-cycle update.
    always_comb begin
        sticky_d  = sticky_q | err_raw;
        errcnt_d  = errcnt_q;
        reqcnt_d  = reqcnt_q;
        respcnt_d = respcnt_q;
        if ((err_raw != 8'h00) && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;
        if (accept) reqcnt_d = reqcnt_q + 32'd1;
        if (resp) respcnt_d = respcnt_q + 32'd1;
        if (Clear_i) begin
            sticky_d  = '0;
            errcnt_d  = '0;
            reqcnt_d  = '0;
            respcnt_d = '0;
        end
    end

    always_ff @(posedge Clk_i or posedge MReset_i) begin
        if (MReset_i) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            data_q    <= '0;
            out_q     <= '0;
            fifo_q    <= '0;
            tmo_q     <= '0;
            sticky_q  <= '0;
            errcnt_q  <= '0;
            reqcnt_q  <= '0;
            respcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            if (capture) begin
                cmd_q  <= MCmd_i;
                addr_q <= MAddr_i;
                be_q   <= MByteEn_i;
                data_q <= MData_i;
            end
            out_q     <= out_d;
            fifo_q    <= fifo_d;
            tmo_q     <= tmo_d;
            sticky_q  <= sticky_d;
            errcnt_q  <= errcnt_d;
            reqcnt_q  <= reqcnt_d;
            respcnt_q <= respcnt_d;
        end
    end

    assign ErrSticky_o   = sticky_q;
    assign ErrCnt_o      = errcnt_q;
    assign Outstanding_o = out_q;
    assign ReqCnt_o      = reqcnt_q;
    assign RespCnt_o     = respcnt_q;

endmodule

// File: tb/tb_ocp_prot_checker.sv
// Directed, table-driven bench for ocp_prot_checker (MAX_OUT=2, ALLOW_WRC=1, TIMEOUT=8).
module tb_ocp_prot_checker;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    logic                Clk = 1'b0;
    logic                MReset = 1'b1;
    logic                Clear = 1'b0;
    logic [2:0]          MCmd = 3'b000;
    logic [ADDR_W-1:0]   MAddr = '0;
    logic [DATA_W/8-1:0] MByteEn = '1;
    logic [DATA_W-1:0]   MData = '0;
    logic                SCmdAccept = 1'b0;
    logic [1:0]          SResp = 2'b00;
    logic [7:0]          Err, ErrSticky;
    logic [15:0]         ErrCnt;
    logic [3:0]          Outst;
    logic [31:0]         ReqCnt, RespCnt;

    int checks = 0;
    int errors = 0;

    ocp_prot_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(2), .WR_RESP(0), .ALLOW_WRC(1), .TIMEOUT(8)
    ) dut (
        .Clk_i(Clk), .MReset_i(MReset), .Clear_i(Clear), .MCmd_i(MCmd), .MAddr_i(MAddr),
        .MByteEn_i(MByteEn), .MData_i(MData), .SCmdAccept_i(SCmdAccept), .SResp_i(SResp),
        .Err_o(Err), .ErrSticky_o(ErrSticky), .ErrCnt_o(ErrCnt), .Outstanding_o(Outst),
        .ReqCnt_o(ReqCnt), .RespCnt_o(RespCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic        acc;
        logic [1:0]  resp;
        logic        clr;
        logic [7:0]  err;     // Err_o during the cycle
        logic [3:0]  outst;   // Outstanding_o after the edge
        logic [7:0]  sticky;  // ErrSticky_o after the edge
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] cmd, input logic [15:0] addr, input logic acc,
                         input logic [1:0] resp, input logic clr);
        MCmd       = cmd;
        MAddr      = addr;
        SCmdAccept = acc;
        SResp      = resp;
        Clear      = clr;
        MByteEn    = '1;
        MData      = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " Err"}, 32'(Err), 32'h0);
        check({tag, " ErrSticky"}, 32'(ErrSticky), 32'h0);
        check({tag, " ErrCnt"}, 32'(ErrCnt), 32'h0);
        check({tag, " Outstanding"}, 32'(Outst), 32'h0);
        check({tag, " ReqCnt"}, ReqCnt, 32'h0);
        check({tag, " RespCnt"}, RespCnt, 32'h0);
    endtask

    initial begin
        //               cmd     addr      acc   resp   clr   err    out   sticky
        vecs[0]  = '{3'b000, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 8'h00};
        vecs[1]  = '{3'b010, 16'h0010, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 8'h00};
        vecs[2]  = '{3'b010, 16'h0010, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 8'h00};
        vecs[3]  = '{3'b010, 16'h0010, 1'b1, 2'b00, 1'b0, 8'h00, 4'd1, 8'h00};
        vecs[4]  = '{3'b000, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 4'd1, 8'h00};
        vecs[5]  = '{3'b000, 16'h0000, 1'b0, 2'b01, 1'b0, 8'h00, 4'd0, 8'h00};
        vecs[6]  = '{3'b001, 16'h0020, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 8'h00};
        vecs[7]  = '{3'b011, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h04, 4'd0, 8'h04};
        vecs[8]  = '{3'b010, 16'h0012, 1'b1, 2'b00, 1'b0, 8'h08, 4'd1, 8'h0C};
        vecs[9]  = '{3'b000, 16'h0000, 1'b0, 2'b10, 1'b0, 8'h10, 4'd0, 8'h1C};
        vecs[10] = '{3'b110, 16'h0030, 1'b1, 2'b00, 1'b0, 8'h00, 4'd1, 8'h1C};
        vecs[11] = '{3'b000, 16'h0000, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 8'h1C};
        vecs[12] = '{3'b000, 16'h0000, 1'b0, 2'b01, 1'b0, 8'h20, 4'd0, 8'h3C};
        vecs[13] = '{3'b000, 16'h0000, 1'b0, 2'b00, 1'b1, 8'h00, 4'd0, 8'h00};
        vecs[14] = '{3'b010, 16'h0040, 1'b1, 2'b01, 1'b0, 8'h20, 4'd0, 8'h20};
        vecs[15] = '{3'b010, 16'h0041, 1'b1, 2'b00, 1'b1, 8'h08, 4'd1, 8'h00};
        vecs[16] = '{3'b010, 16'h0044, 1'b1, 2'b01, 1'b0, 8'h00, 4'd1, 8'h00};
        vecs[17] = '{3'b000, 16'h0000, 1'b0, 2'b01, 1'b0, 8'h00, 4'd0, 8'h00};

        // Reset: outputs zero and Err_o masked even with bad inputs present.
        drive(3'b111, 16'h0003, 1'b1, 2'b01, 1'b0);
        #2;
        check_all_zero("reset");
        tick();
        tick();
        MReset = 1'b0;
        drive(3'b000, 16'h0000, 1'b0, 2'b00, 1'b0);

        // Table vectors.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].acc, vecs[i].resp, vecs[i].clr);
            #1;
            check($sformatf("vec%0d Err", i), 32'(Err), 32'(vecs[i].err));
            tick();
            check($sformatf("vec%0d Outstanding", i), 32'(Outst), 32'(vecs[i].outst));
            check($sformatf("vec%0d ErrSticky", i), 32'(ErrSticky), 32'(vecs[i].sticky));
        end
        check("table ReqCnt", ReqCnt, 32'd1);
        check("table RespCnt", RespCnt, 32'd2);
        check("table ErrCnt", 32'(ErrCnt), 32'd0);

        // Hold violation on address change, including the accepting cycle.
        drive(3'b010, 16'h0010, 1'b0, 2'b00, 1'b0);
        #1; check("hold enter Err", 32'(Err), 32'h00);
        tick();
        drive(3'b010, 16'h0014, 1'b0, 2'b00, 1'b0);
        #1; check("hold addr Err", 32'(Err), 32'h02);
        tick();
        check("hold sticky", 32'(ErrSticky), 32'h02);
        check("hold ErrCnt", 32'(ErrCnt), 32'd1);
        drive(3'b010, 16'h0014, 1'b1, 2'b00, 1'b0);
        #1; check("hold accept Err", 32'(Err), 32'h02);
        tick();
        check("hold ErrCnt2", 32'(ErrCnt), 32'd2);
        check("hold Outstanding", 32'(Outst), 32'd1);
        drive(3'b000, 16'h0000, 1'b0, 2'b01, 1'b0);
        tick();
        check("hold drain", 32'(Outst), 32'd0);
        // Hold violation on write data change.
        drive(3'b001, 16'h0020, 1'b0, 2'b00, 1'b0);
        tick();
        drive(3'b001, 16'h0020, 1'b1, 2'b00, 1'b0);
        MData = 32'h0000_DEAD;
        #1; check("hold data Err", 32'(Err), 32'h02);
        tick();
        check("hold ErrCnt3", 32'(ErrCnt), 32'd3);
        check("wr no outstanding", 32'(Outst), 32'd0);

        // Overflow at MAX_OUT=2, then drain and an unmatched response.
        drive(3'b010, 16'h0000, 1'b1, 2'b00, 1'b0);
        tick();
        tick();
        check("ovf two", 32'(Outst), 32'd2);
        #1; check("ovf Err", 32'(Err), 32'h40);
        tick();
        check("ovf saturate", 32'(Outst), 32'd2);
        drive(3'b000, 16'h0000, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        check("ovf drained", 32'(Outst), 32'd0);
        #1; check("unmatched Err", 32'(Err), 32'h20);
        tick();
        check("unmatched stays 0", 32'(Outst), 32'd0);

        // Timeout: pulses in the 8th and 16th cycle after the accept edge.
        drive(3'b000, 16'h0000, 1'b0, 2'b00, 1'b1);
        tick();
        drive(3'b010, 16'h0000, 1'b1, 2'b00, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            drive(3'b000, 16'h0000, 1'b0, 2'b00, 1'b0);
            #1;
            check($sformatf("tmo cyc%0d Err", k), 32'(Err),
                  (k == 8 || k == 16) ? 32'h80 : 32'h00);
            tick();
        end
        check("tmo ErrCnt", 32'(ErrCnt), 32'd2);
        check("tmo sticky", 32'(ErrSticky), 32'h80);

        // Async reset with outstanding requests and the FSM in WAIT.
        drive(3'b010, 16'h0000, 1'b1, 2'b00, 1'b0);
        tick();
        check("pre-rst Outstanding", 32'(Outst), 32'd2);
        drive(3'b010, 16'h0050, 1'b0, 2'b00, 1'b0);
        tick();
        #2;
        MReset = 1'b1;
        drive(3'b111, 16'h0001, 1'b0, 2'b01, 1'b0);
        #1;
        check_all_zero("async rst");
        tick();
        tick();
        MReset = 1'b0;
        drive(3'b000, 16'h0000, 1'b0, 2'b01, 1'b0);
        #1; check("post-rst Err", 32'(Err), 32'h20);
        tick();
        check("post-rst Outstanding", 32'(Outst), 32'd0);
        check("post-rst RespCnt", RespCnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
